// File: rtl/sram_burst_ctrl_pkg.sv
// Shared definitions for the SRAM burst controller and its processor-side requester.
package sram_burst_ctrl_pkg;

    // Default widths; must match the attached single-port SRAM.
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_LEN_W  = 4;

    // Controller state encoding.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WRITE    = 2'd1,
        ST_READ     = 2'd2,
        ST_RD_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/sram_burst_ctrl.sv
// Burst controller for a single-port synchronous SRAM on a shared tristate bus.
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; the requester holds its request (and write beat) stable until then.
// Read data returns as one rdata_valid pulse per beat with no backpressure.
module sram_burst_ctrl
    import sram_burst_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_cs,
    output logic              mem_we,
    output logic              mem_oe,
    output logic [ADDR_W-1:0] mem_addr,
    inout  wire  [DATA_W-1:0] mem_data,
    output state_t            o_dbg_state
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rdata_valid;
    logic              r_cap_arm;
    logic              w_capture;
    logic              w_cs;
    logic              w_we;
    logic              w_oe;
    logic              w_req_ready;
    logic              w_wdata_ready;
    logic              w_last;

    assign w_last = (r_cnt == '0);

    // State register; reset forces IDLE so all control pins drop at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: every burst starts from and returns to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (req_valid) w_state_nxt = req_write ? ST_WRITE : ST_READ;
            ST_WRITE:    if (wdata_valid && w_last) w_state_nxt = ST_IDLE;
            ST_READ:     if (w_last) w_state_nxt = ST_RD_DRAIN;
            ST_RD_DRAIN: w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: drive the bus only while writing, so we and oe never overlap.
    always_comb begin
        w_cs          = 1'b0;
        w_we          = 1'b0;
        w_oe          = 1'b0;
        w_req_ready   = 1'b0;
        w_wdata_ready = 1'b0;
        w_capture     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_ready = 1'b1;
            end
            ST_WRITE: begin
                w_cs          = wdata_valid;
                w_we          = wdata_valid;
                w_wdata_ready = wdata_valid;
            end
            ST_READ: begin
                w_cs      = 1'b1;
                w_oe      = 1'b1;
                // The SRAM output is one edge behind the address, so skip the first cycle.
                w_capture = r_cap_arm;
            end
            ST_RD_DRAIN: begin
                w_cs      = 1'b1;
                w_oe      = 1'b1;
                w_capture = 1'b1;
            end
            default: begin
                w_cs = 1'b0;
            end
        endcase
    end

    // Address/count sequencing and registered read-data capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr        <= '0;
            r_cnt         <= '0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_cap_arm     <= 1'b0;
        end else begin
            r_cap_arm     <= (r_state == ST_READ);
            r_rdata_valid <= w_capture;
            if (w_capture) begin
                r_rdata <= mem_data;
            end
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_addr <= req_addr;
                        r_cnt  <= req_len;
                    end
                end
                ST_WRITE: begin
                    if (wdata_valid && !w_last) begin
                        r_addr <= r_addr + 1'b1;
                        r_cnt  <= r_cnt - 1'b1;
                    end
                end
                ST_READ: begin
                    if (!w_last) begin
                        r_addr <= r_addr + 1'b1;
                        r_cnt  <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_addr <= r_addr;
                end
            endcase
        end
    end

    assign mem_data    = w_we ? wdata : {DATA_W{1'bz}};
    assign mem_cs      = w_cs;
    assign mem_we      = w_we;
    assign mem_oe      = w_oe;
    assign mem_addr    = r_addr;
    assign req_ready   = w_req_ready;
    assign wdata_ready = w_wdata_ready;
    assign rdata_valid = r_rdata_valid;
    assign rdata       = r_rdata;
    assign busy        = (r_state != ST_IDLE);
    assign o_dbg_state = r_state;

endmodule
